// File: rtl/bigger_or_gate_sync_if.sv
// Signal bundle for bigger_or_gate_sync: OR operands, instant result and clocked side-band.
// BIGGER_OR_GATE_STICKY_EN adds the sticky flag.
interface bigger_or_gate_sync_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in0;
  logic             in1;
  logic             in2;
  logic             out;
  logic             out_q;
  logic             rise;
  logic [CNT_W-1:0] hi_cnt;
`ifdef BIGGER_OR_GATE_STICKY_EN
  logic             sticky;
`endif

  modport master (
    output in0, in1, in2,
`ifdef BIGGER_OR_GATE_STICKY_EN
    input  sticky,
`endif
    input  out, out_q, rise, hi_cnt
  );

  modport slave (
    input  in0, in1, in2,
`ifdef BIGGER_OR_GATE_STICKY_EN
    output sticky,
`endif
    output out, out_q, rise, hi_cnt
  );
endinterface

// File: rtl/bigger_or_gate_sync.sv
// Three-input OR with zero-latency output plus registered copy, rise pulse and saturating high-cycle count.
// Optional sticky flag enabled by BIGGER_OR_GATE_STICKY_EN.
module bigger_or_gate_sync #(
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  bigger_or_gate_sync_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             or_val;
  logic             out_q;
  logic             rise;
  logic [CNT_W-1:0] hi_cnt;

  // Plain OR so unmasked X on an input reaches out unresolved
  assign or_val = bus.in0 | bus.in1 | bus.in2;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= 1'b0;
      rise   <= 1'b0;
      hi_cnt <= '0;
    end else begin
      out_q <= or_val;
      rise  <= or_val & ~out_q;
      if (or_val && (hi_cnt != CNT_MAX))
        hi_cnt <= hi_cnt + 1'b1;
    end
  end

`ifdef BIGGER_OR_GATE_STICKY_EN
  logic sticky;

  always_ff @(posedge clk) begin
    if (rst)
      sticky <= 1'b0;
    else
      sticky <= sticky | or_val;
  end

  assign bus.sticky = sticky;
`endif

  assign bus.out    = or_val;
  assign bus.out_q  = out_q;
  assign bus.rise   = rise;
  assign bus.hi_cnt = hi_cnt;
endmodule

// File: tb/tb_bigger_or_gate_sync.sv
// Self-checking bench for bigger_or_gate_sync: default-width and 2-bit-counter instances share stimulus.
module tb_bigger_or_gate_sync;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic [2:0] cur = 3'b000;

  int checks = 0;
  int failures = 0;

  int ref_q = 0;
  int ref_rise = 0;
  int ref_cnt8 = 0;
  int ref_cnt2 = 0;
  int ref_sticky = 0;

  bigger_or_gate_sync_if #(.CNT_W(8)) bus8 ();
  bigger_or_gate_sync_if #(.CNT_W(2)) bus2 ();

  bigger_or_gate_sync #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  bigger_or_gate_sync #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    cur = v;
    bus8.in0 = v[0]; bus8.in1 = v[1]; bus8.in2 = v[2];
    bus2.in0 = v[0]; bus2.in1 = v[1]; bus2.in2 = v[2];
  endtask

  function automatic int or_of(input logic [2:0] v);
    return ((int'(v[0]) + int'(v[1]) + int'(v[2])) > 0) ? 1 : 0;
  endfunction

  task automatic check_out(input string tag);
    check({tag, "_out8"}, 32'(bus8.out), 32'(or_of(cur)));
    check({tag, "_out2"}, 32'(bus2.out), 32'(or_of(cur)));
  endtask

  // Advance one edge: the reference is computed from the rules, then all outputs compared
  task automatic tick(input string tag);
    int o;
    int nq, nr, n8, n2, ns;
    o = or_of(cur);
    if (rst) begin
      nq = 0; nr = 0; n8 = 0; n2 = 0; ns = 0;
    end else begin
      nq = o;
      nr = (o == 1 && ref_q == 0) ? 1 : 0;
      n8 = (o == 1) ? ((ref_cnt8 + 1 > 255) ? 255 : ref_cnt8 + 1) : ref_cnt8;
      n2 = (o == 1) ? ((ref_cnt2 + 1 > 3) ? 3 : ref_cnt2 + 1) : ref_cnt2;
      ns = (ref_sticky == 1 || o == 1) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    ref_q = nq; ref_rise = nr; ref_cnt8 = n8; ref_cnt2 = n2; ref_sticky = ns;
    check({tag, "_out_q"},  32'(bus8.out_q),  32'(ref_q));
    check({tag, "_rise"},   32'(bus8.rise),   32'(ref_rise));
    check({tag, "_hi_cnt"}, 32'(bus8.hi_cnt), 32'(ref_cnt8));
    check({tag, "_out_q2"}, 32'(bus2.out_q),  32'(ref_q));
    check({tag, "_rise2"},  32'(bus2.rise),   32'(ref_rise));
    check({tag, "_hi_cnt2"}, 32'(bus2.hi_cnt), 32'(ref_cnt2));
    check_out(tag);
`ifdef BIGGER_OR_GATE_STICKY_EN
    check({tag, "_sticky"}, 32'(bus8.sticky), 32'(ref_sticky));
`endif
  endtask

  initial begin
    drive(3'b000);

    // Truth table with the clock stopped
    for (int i = 0; i < 8; i++) begin
      drive(3'(i));
      #1;
      check("tt", 32'(bus8.out), (i == 0) ? 32'd0 : 32'd1);
      check("tt2", 32'(bus2.out), (i == 0) ? 32'd0 : 32'd1);
      #1;
    end

    clk_en = 1'b1;
    drive(3'b111);
    rst = 1'b1;
    tick("rst_a");
    tick("rst_b");
    check("rst_hold_out", 32'(bus8.out), 32'd1);
    check("rst_hi_cnt", 32'(bus8.hi_cnt), 32'd0);

    rst = 1'b0;
    drive(3'b000);
    tick("idle_a");
    tick("idle_b");
    drive(3'b010);
    tick("rise_a");
    check("rise_first", 32'(bus8.rise), 32'd1);
    tick("rise_b");
    check("rise_once", 32'(bus8.rise), 32'd0);
    tick("rise_c");
    check("rise_cnt3", 32'(bus8.hi_cnt), 32'd3);

    // Narrow counter saturates at 3
    rst = 1'b1; tick("sat_rst"); rst = 1'b0;
    drive(3'b001);
    for (int i = 0; i < 6; i++) tick("sat");
    check("sat_hold", 32'(bus2.hi_cnt), 32'd3);

    // Mid-run reset
    rst = 1'b1; tick("mid_rst0"); rst = 1'b0;
    drive(3'b100);
    for (int i = 0; i < 5; i++) tick("mid_run");
    check("mid_cnt5", 32'(bus8.hi_cnt), 32'd5);
    rst = 1'b1;
    tick("mid_rst");
    check("mid_rst_cnt", 32'(bus8.hi_cnt), 32'd0);
    rst = 1'b0;
    tick("mid_rel");
    check("mid_rel_rise", 32'(bus8.rise), 32'd1);

    // Default-width counter saturates at 255
    drive(3'b111);
    for (int i = 0; i < 260; i++) tick("sat8");
    check("sat8_hold", 32'(bus8.hi_cnt), 32'd255);

`ifdef BIGGER_OR_GATE_STICKY_EN
    rst = 1'b1; tick("st_rst0"); rst = 1'b0;
    drive(3'b001);
    tick("st_set");
    drive(3'b000);
    for (int i = 0; i < 4; i++) tick("st_hold");
    check("st_stays", 32'(bus8.sticky), 32'd1);
    rst = 1'b1;
    tick("st_clr");
    check("st_cleared", 32'(bus8.sticky), 32'd0);
    rst = 1'b0;
`endif

    // Random inputs, occasional reset, glitches between edges
    for (int i = 0; i < 300; i++) begin
      drive(3'($urandom_range(0, 7)));
      #2;
      check_out("glitch");
      drive(3'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 15) == 0);
      #1;
      check_out("rand_pre");
      tick("rand");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bigger_or_gate_sync.md
Name: bigger_or_gate_sync

Overview:
- Three-input OR gate for the gate-level library tier.
- Primary output `out` is purely combinational (in0 | in1 | in2), so it is valid with no clock edge.
- Clocked side-band adds:
  - a registered copy of the OR result
  - a rising-edge pulse
  - a saturating count of cycles with the OR result high
- Used wherever downstream logic needs both the instant OR and a synchronised version.

Parameters:
- CNT_W, default 8: width of the high-cycle counter `hi_cnt`; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in0  input  1  OR operand 0.
- in1  input  1  OR operand 1.
- in2  input  1  OR operand 2.
- out  output 1  combinational in0 | in1 | in2; zero latency; independent of clk and rst.
- out_q  output 1  out registered one cycle.
- rise  output 1  one-cycle pulse when out_q goes 0->1.
- hi_cnt  output CNT_W  count of clock edges at which out was 1, saturating.

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `rst` is synchronous and active-high.
  - No other clocks and no asynchronous paths into registers.
- `out`:
  - out = in0 | in1 | in2 at all times, including while rst = 1.
  - Truth table: 0 only for in0 = in1 = in2 = 0; 1 for the other seven combinations.
  - An X on any input that is not masked by a 1 propagates to out; inputs are not resolved.
- Reset (rst = 1 at a rising edge of clk):
  - out_q <= 0, rise <= 0, hi_cnt <= 0.
  - rst has priority over every other update on the same edge.
- Normal edge (rst = 0):
  - out_q <= out.
  - rise <= out & ~out_q, using the old out_q. rise is registered, so it is high in the same cycle that out_q first shows 1.
  - hi_cnt <= hi_cnt + 1 if out = 1 and hi_cnt is below its maximum (2^CNT_W - 1); otherwise it holds.
- Saturation: hi_cnt stays at all-ones and never wraps to 0.
- Latency:
  - out: 0 cycles.
  - out_q and hi_cnt: 1 cycle.
  - rise: asserts on the same edge that out_q goes 0->1.
- Reset mid-operation:
  - Registers clear on the reset edge.
  - out keeps tracking the inputs.
  - On the first edge after reset releases with out = 1: out_q goes to 1, rise pulses once, hi_cnt goes to 1.
- Glitches: input changes between clock edges affect only out, never the registers.
- After a reset edge no output is X, provided the inputs are known.

Optional Feature:
- Macro: BIGGER_OR_GATE_STICKY_EN.
- When defined:
  - Adds output port `sticky` (1 bit).
  - sticky <= 0 on a reset edge.
  - Otherwise sticky <= sticky | out on each edge; it stays 1 until the next reset.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Truth-table sweep: step {in2,in1,in0} through 000..111 every 2 time units with no clock edges -> out = 0 for 000 and 1 for 001..111, within the same timestep.
- Reset: drive inputs 111 and hold rst = 1 for 2 edges -> out = 1; out_q = 0, rise = 0, hi_cnt = 0 after each edge.
- Rise pulse:
  - Release reset with inputs 000 for 2 edges, then set in1 = 1 for 3 edges.
  - Required: out_q is 0,0,1,1,1; rise is 0,0,1,0,0; hi_cnt ends at 3.
- Saturation: CNT_W = 2, hold in0 = 1 for 6 edges -> hi_cnt is 1,2,3,3,3,3 with no wrap.
- Mid-run reset: after hi_cnt = 5, pulse rst for 1 edge with in2 = 1 -> hi_cnt = 0 and out_q = 0; on the next edge hi_cnt = 1, out_q = 1, rise = 1.
- Sticky, with BIGGER_OR_GATE_STICKY_EN defined: in0 = 1 for 1 edge, then 000 for 4 edges -> sticky stays 1; a reset edge -> sticky = 0.
